char_rotator: RTL and testbench

Clocked controller that scrolls four 2-bit character codes across HEX3..HEX0 of the board. Generates the rotating select for the team's 2-bit-wide 4-to-1 multiplexer stage, one per display position, then decodes each selected code to active-low 7-segment patterns. Rotation advances automatically from a prescaled tick when `Run` is high, or by one position per rising edge of `Step`.

---
 rtl/char_rotator_pkg.sv | 42 ++++
 rtl/char_7seg.sv | 19 +
 rtl/char_rotator.sv | 95 +++++++++
 tb/tb_char_rotator.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/char_rotator_pkg.sv
// Shared character codes, segment patterns and rotation state type for the
// four-position scrolling display.
package char_rotator_pkg;

    localparam logic [1:0] CODE_D     = 2'b00;
    localparam logic [1:0] CODE_E     = 2'b01;
    localparam logic [1:0] CODE_ONE   = 2'b10;
    localparam logic [1:0] CODE_BLANK = 2'b11;

    // Active-low segments, bit order [6:0] = g,f,e,d,c,b,a
    localparam int         SEG_W     = 7;
    localparam logic [6:0] SEG_D     = 7'b0100001;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_ONE   = 7'b1111001;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef enum logic [1:0] {
        ROT0 = 2'd0,
        ROT1 = 2'd1,
        ROT2 = 2'd2,
        ROT3 = 2'd3
    } rot_state_t;

    function automatic rot_state_t rot_next(input rot_state_t s);
        logic [1:0] n;
        n = s + 2'd1;
        return rot_state_t'(n);
    endfunction

    // 2-bit-wide 4-to-1 mux over the packed character groups U,V,W,X
    function automatic logic [1:0] pick_code(input logic [7:0] chars, input logic [1:0] sel);
        logic [1:0] c;
        case (sel)
            2'd0:    c = chars[1:0];
            2'd1:    c = chars[3:2];
            2'd2:    c = chars[5:4];
            default: c = chars[7:6];
        endcase
        return c;
    endfunction

endpackage

// File: rtl/char_7seg.sv
// Combinational 2-bit character code to active-low 7-segment decoder.
module char_7seg
    import char_rotator_pkg::*;
(
    input  logic [1:0]       code,
    output logic [SEG_W-1:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (code)
            CODE_D:   seg = SEG_D;
            CODE_E:   seg = SEG_E;
            CODE_ONE: seg = SEG_ONE;
            default:  seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/char_rotator.sv
// Scrolls four 2-bit characters across HEX3..HEX0, advancing on a prescaled
// tick while Run is high or once per rising edge of Step.
//
//   state | meaning
//   ROT0  | HEX3..HEX0 show U,V,W,X
//   ROT1  | HEX3..HEX0 show V,W,X,U
//   ROT2  | HEX3..HEX0 show W,X,U,V
//   ROT3  | HEX3..HEX0 show X,U,V,W
module char_rotator
    import char_rotator_pkg::*;
#(
    parameter int TICK_DIV = 50000000
) (
    input  logic       CLOCK_50,
    input  logic       Reset,
    input  logic [7:0] Chars,
    input  logic       Run,
    input  logic       Step,
    output logic [1:0] Sel,
    output logic       Tick,
    output logic [6:0] HEX0,
    output logic [6:0] HEX1,
    output logic [6:0] HEX2,
    output logic [6:0] HEX3
);

    localparam int               CNT_W    = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    rot_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic             step_s;
    logic             step_q;
    logic             step_edge;
    logic             cnt_tc;
    logic             advance;

    // Step is sampled into step_s first, so a Step held through reset only
    // counts as an edge from the second sample after release.
    assign step_edge = step_s & ~step_q;
    assign cnt_tc    = Run && (cnt == CNT_LAST);
    assign advance   = step_edge | cnt_tc;

    always_ff @(posedge CLOCK_50 or posedge Reset) begin
        if (Reset) begin
            state  <= ROT0;
            cnt    <= '0;
            step_s <= 1'b0;
            step_q <= 1'b0;
            Tick   <= 1'b0;
        end else begin
            step_s <= Step;
            step_q <= step_s;
            Tick   <= advance;
            if (advance)
                state <= rot_next(state);
            if (step_edge || cnt_tc)
                cnt <= '0;
            else if (Run)
                cnt <= cnt + CNT_W'(1);
        end
    end

    assign Sel = state;

    logic [1:0]       pos_code [4];
    logic [SEG_W-1:0] pos_seg  [4];

    // Position i drives HEX(3-i) and shows group (state + i) mod 4.
    for (genvar i = 0; i < 4; i++) begin : g_pos
        logic [1:0] pos_sel;
        assign pos_sel     = state + 2'(i);
        assign pos_code[i] = pick_code(Chars, pos_sel);

        char_7seg u_seg (
            .code (pos_code[i]),
            .seg  (pos_seg[i])
        );
    end

    always_ff @(posedge CLOCK_50 or posedge Reset) begin
        if (Reset) begin
            HEX3 <= SEG_BLANK;
            HEX2 <= SEG_BLANK;
            HEX1 <= SEG_BLANK;
            HEX0 <= SEG_BLANK;
        end else begin
            HEX3 <= pos_seg[0];
            HEX2 <= pos_seg[1];
            HEX1 <= pos_seg[2];
            HEX0 <= pos_seg[3];
        end
    end

endmodule

// File: tb/tb_char_rotator.sv
// Directed bench for char_rotator with TICK_DIV=4: reset, auto, step,
// collision, pause/resume and mid-count reset.
module tb_char_rotator;

    localparam logic [6:0] P_D   = 7'b0100001;
    localparam logic [6:0] P_E   = 7'b0000110;
    localparam logic [6:0] P_ONE = 7'b1111001;
    localparam logic [6:0] P_BLK = 7'b1111111;

    logic       CLOCK_50;
    logic       Reset;
    logic [7:0] Chars;
    logic       Run;
    logic       Step;
    logic [1:0] Sel;
    logic       Tick;
    logic [6:0] HEX0, HEX1, HEX2, HEX3;

    int n_checks = 0;
    int n_fail   = 0;

    char_rotator #(.TICK_DIV(4)) dut (
        .CLOCK_50 (CLOCK_50),
        .Reset    (Reset),
        .Chars    (Chars),
        .Run      (Run),
        .Step     (Step),
        .Sel      (Sel),
        .Tick     (Tick),
        .HEX0     (HEX0),
        .HEX1     (HEX1),
        .HEX2     (HEX2),
        .HEX3     (HEX3)
    );

    initial CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance n rising edges, then settle 1 time unit past the last edge.
    task automatic cyc(input int n);
        repeat (n) @(posedge CLOCK_50);
        #1;
    endtask

    initial begin
        Reset = 1'b1;
        Chars = 8'b11100100;
        Run   = 1'b0;
        Step  = 1'b0;

        // Reset / hold
        cyc(2);
        chk("rst_sel",  {30'd0, Sel}, 32'd0);
        chk("rst_tick", {31'd0, Tick}, 32'd0);
        chk("rst_hex",  {4'd0, HEX3, HEX2, HEX1, HEX0}, {4'd0, P_BLK, P_BLK, P_BLK, P_BLK});
        Reset = 1'b0;
        cyc(2);
        chk("hold_hex", {4'd0, HEX3, HEX2, HEX1, HEX0}, {4'd0, P_D, P_E, P_ONE, P_BLK});
        chk("hold_sel", {30'd0, Sel}, 32'd0);

        // Auto mode: one advance every 4 cycles, 0->1->2->3->0
        Run = 1'b1;
        for (int s = 1; s <= 4; s++) begin
            for (int k = 0; k < 3; k++) begin
                cyc(1);
                chk("auto_tick_lo", {31'd0, Tick}, 32'd0);
                chk("auto_sel_hold", {30'd0, Sel}, 32'((s - 1) % 4));
                if (s == 2 && k == 0)
                    chk("auto_hex_sel1", {4'd0, HEX3, HEX2, HEX1, HEX0},
                        {4'd0, P_E, P_ONE, P_BLK, P_D});
            end
            cyc(1);
            chk("auto_tick_hi", {31'd0, Tick}, 32'd1);
            chk("auto_sel_adv", {30'd0, Sel}, 32'(s % 4));
        end
        Run = 1'b0;

        // Step held high 5 cycles: a single advance, one cycle after the sample
        Step = 1'b1;
        cyc(1);
        chk("step_sample_sel",  {30'd0, Sel}, 32'd0);
        chk("step_sample_tick", {31'd0, Tick}, 32'd0);
        cyc(1);
        chk("step_adv_sel",  {30'd0, Sel}, 32'd1);
        chk("step_adv_tick", {31'd0, Tick}, 32'd1);
        for (int k = 0; k < 3; k++) begin
            cyc(1);
            chk("step_held_sel",  {30'd0, Sel}, 32'd1);
            chk("step_held_tick", {31'd0, Tick}, 32'd0);
        end
        Step = 1'b0;
        cyc(2);

        // Chars change reaches HEX without touching Sel
        Chars = 8'b00011011;
        cyc(1);
        chk("chars_hex", {4'd0, HEX3, HEX2, HEX1, HEX0}, {4'd0, P_ONE, P_E, P_D, P_BLK});
        chk("chars_sel", {30'd0, Sel}, 32'd1);
        Chars = 8'b11100100;

        // Collision: step edge lands on the cnt=3 cycle
        Run = 1'b1;
        cyc(2);
        Step = 1'b1;
        cyc(1);
        chk("coll_pre_sel",  {30'd0, Sel}, 32'd1);
        chk("coll_pre_tick", {31'd0, Tick}, 32'd0);
        cyc(1);
        chk("coll_sel",  {30'd0, Sel}, 32'd2);
        chk("coll_tick", {31'd0, Tick}, 32'd1);
        cyc(1);
        chk("coll_single_sel",  {30'd0, Sel}, 32'd2);
        chk("coll_single_tick", {31'd0, Tick}, 32'd0);
        Step = 1'b0;
        cyc(2);
        chk("coll_next_hold", {30'd0, Sel}, 32'd2);
        cyc(1);
        chk("coll_next_sel",  {30'd0, Sel}, 32'd3);
        chk("coll_next_tick", {31'd0, Tick}, 32'd1);

        // Pause/resume: count 2 held across 10 idle cycles
        cyc(2);
        Run = 1'b0;
        cyc(10);
        chk("pause_sel",  {30'd0, Sel}, 32'd3);
        chk("pause_tick", {31'd0, Tick}, 32'd0);
        Run = 1'b1;
        cyc(1);
        chk("resume_hold", {30'd0, Sel}, 32'd3);
        cyc(1);
        chk("resume_sel",  {30'd0, Sel}, 32'd0);
        chk("resume_tick", {31'd0, Tick}, 32'd1);

        // Mid-operation reset at cnt=2, Sel=3
        cyc(14);
        chk("mid_pre_sel",  {30'd0, Sel}, 32'd3);
        chk("mid_pre_hex0", {25'd0, HEX0}, {25'd0, P_ONE});
        #3;
        Reset = 1'b1;
        #1;
        chk("mid_rst_sel",  {30'd0, Sel}, 32'd0);
        chk("mid_rst_tick", {31'd0, Tick}, 32'd0);
        chk("mid_rst_hex",  {4'd0, HEX3, HEX2, HEX1, HEX0}, {4'd0, P_BLK, P_BLK, P_BLK, P_BLK});
        cyc(1);
        Reset = 1'b0;
        cyc(3);
        chk("post_rst_hold", {30'd0, Sel}, 32'd0);
        cyc(1);
        chk("post_rst_sel",  {30'd0, Sel}, 32'd1);
        chk("post_rst_tick", {31'd0, Tick}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
